// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - LC-3b memory-stage access controller (optional perf counters: MEM_ACCESS_PERF_EN)
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [2:0]  mem_op,
    input  logic [15:0] address,
    input  logic [15:0] store_data,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic [15:0] load_data,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_accesses
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LDW  = 3'd1;
    localparam logic [2:0] OP_LDB  = 3'd2;
    localparam logic [2:0] OP_STW  = 3'd3;
    localparam logic [2:0] OP_STB  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_STI  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_SECOND = 1'b1;

    logic [0:0]  r_state;
    // Bit 0 of the fetched pointer is never used: the second access is always word aligned.
    logic [15:1] r_ind_addr;

    logic        w_active;
    logic        w_indirect;
    logic        w_single;
    logic        w_in_second;
    logic        w_op_ldw;
    logic        w_op_ldb;
    logic        w_op_ldi;
    logic        w_op_sti;
    logic [1:0]  w_byte_be;
    logic [15:0] w_word_addr;
    logic [7:0]  w_sel_byte;

    // Decode the presented operation; nothing is active while reset is asserted.
    always_comb begin
        w_op_ldw    = (mem_op == OP_LDW);
        w_op_ldb    = (mem_op == OP_LDB);
        w_op_ldi    = (mem_op == OP_LDI);
        w_op_sti    = (mem_op == OP_STI);
        w_active    = rst_n & valid & (mem_op != OP_NONE) & (mem_op != OP_RSVD);
        w_indirect  = w_op_ldi | w_op_sti;
        w_single    = w_active & ~w_indirect;
        w_in_second = w_active & w_indirect & (r_state == S_SECOND);
        w_byte_be   = address[0] ? 2'b10 : 2'b01;
        w_word_addr = {address[15:1], 1'b0};
        w_sel_byte  = address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
    end

    // Drive the cache request for the current access (first access or indirect second access).
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        if (w_in_second) begin
            dmem_read        = w_op_ldi;
            dmem_write       = w_op_sti;
            dmem_address     = {r_ind_addr, 1'b0};
            dmem_wdata       = w_op_sti ? store_data : 16'h0000;
            dmem_byte_enable = 2'b11;
        end else if (w_active) begin
            case (mem_op)
                OP_LDW, OP_LDI, OP_STI: begin
                    dmem_read        = 1'b1;
                    dmem_address     = w_word_addr;
                    dmem_byte_enable = 2'b11;
                end
                OP_LDB: begin
                    dmem_read        = 1'b1;
                    dmem_address     = address;
                    dmem_byte_enable = w_byte_be;
                end
                OP_STW: begin
                    dmem_write       = 1'b1;
                    dmem_address     = w_word_addr;
                    dmem_wdata       = store_data;
                    dmem_byte_enable = 2'b11;
                end
                OP_STB: begin
                    dmem_write       = 1'b1;
                    dmem_address     = address;
                    dmem_wdata       = {store_data[7:0], store_data[7:0]};
                    dmem_byte_enable = w_byte_be;
                end
                default: begin
                    dmem_read  = 1'b0;
                    dmem_write = 1'b0;
                end
            endcase
        end
    end

    // Stall until the final access of the op completes; return load data on that response.
    always_comb begin
        mem_stall = w_active & ~(dmem_resp & (w_single | w_in_second));
        load_data = 16'h0000;
        if (w_active && dmem_resp) begin
            if (w_op_ldw || (w_op_ldi && w_in_second)) begin
                load_data = dmem_rdata;
            end else if (w_op_ldb) begin
                load_data = {{8{w_sel_byte[7]}}, w_sel_byte};
            end
        end
    end

    // Indirect sequencing: capture the pointer on the first response, finish on the second.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ind_addr <= 15'h0000;
        end else if (w_in_second) begin
            if (dmem_resp) begin
                r_state <= S_IDLE;
            end
        end else if (w_active && w_indirect && dmem_resp) begin
            r_state    <= S_SECOND;
            r_ind_addr <= dmem_rdata[15:1];
        end else begin
            r_state <= S_IDLE;
        end
    end

`ifdef MEM_ACCESS_PERF_EN
    logic [31:0] r_perf_stall_cycles;
    logic [31:0] r_perf_accesses;

    // Count stalled cycles and completed cache accesses; both wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall_cycles <= 32'h0;
            r_perf_accesses     <= 32'h0;
        end else begin
            if (mem_stall) begin
                r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
            end
            if (w_active && dmem_resp) begin
                r_perf_accesses <= r_perf_accesses + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = rst_n ? r_perf_stall_cycles : 32'h0;
    assign perf_accesses     = rst_n ? r_perf_accesses     : 32'h0;
`else
    assign perf_stall_cycles = 32'h0;
    assign perf_accesses     = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [2:0]  mem_op;
    logic [15:0] address;
    logic [15:0] store_data;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall;
    logic [15:0] load_data;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_accesses;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Model state: accesses already completed for the current op, fetched pointer, counters.
    int          m_done = 0;
    logic [15:0] m_ptr  = 16'h0;
    int unsigned m_stall_cnt = 0;
    int unsigned m_acc_cnt   = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        stall;
        logic [15:0] ld;
    } exp_t;

    mem_access_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid             (valid),
        .mem_op            (mem_op),
        .address           (address),
        .store_data        (store_data),
        .dmem_read         (dmem_read),
        .dmem_write        (dmem_write),
        .dmem_address      (dmem_address),
        .dmem_wdata        (dmem_wdata),
        .dmem_byte_enable  (dmem_byte_enable),
        .dmem_rdata        (dmem_rdata),
        .dmem_resp         (dmem_resp),
        .mem_stall         (mem_stall),
        .load_data         (load_data),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_accesses     (perf_accesses)
    );

    always #5 clk = ~clk;

    function automatic logic is_active();
        return rst_n && valid && (mem_op >= 3'd1) && (mem_op <= 3'd6);
    endfunction

    function automatic exp_t model();
        exp_t        e;
        int          needed;
        int          idx;
        logic        last;
        logic [7:0]  b;
        logic [7:0]  sb;
        e = '0;
        if (!is_active()) return e;
        needed = (mem_op == 3'd5 || mem_op == 3'd6) ? 2 : 1;
        idx    = (needed == 2) ? m_done : 0;
        last   = (idx == needed - 1);
        sb     = store_data[7:0];
        if (idx == 1) begin
            e.addr = m_ptr & 16'hFFFE;
            e.be   = 2'b11;
            if (mem_op == 3'd6) begin
                e.wr    = 1'b1;
                e.wdata = store_data;
            end else begin
                e.rd = 1'b1;
            end
        end else begin
            case (mem_op)
                3'd2: begin e.rd = 1'b1; e.addr = address; e.be = address[0] ? 2'b10 : 2'b01; end
                3'd3: begin e.wr = 1'b1; e.addr = address & 16'hFFFE; e.wdata = store_data; e.be = 2'b11; end
                3'd4: begin e.wr = 1'b1; e.addr = address; e.wdata = {sb, sb}; e.be = address[0] ? 2'b10 : 2'b01; end
                default: begin e.rd = 1'b1; e.addr = address & 16'hFFFE; e.be = 2'b11; end
            endcase
        end
        e.stall = !(dmem_resp && last);
        if (dmem_resp && last) begin
            if (mem_op == 3'd1 || mem_op == 3'd5) begin
                e.ld = dmem_rdata;
            end else if (mem_op == 3'd2) begin
                b    = address[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
                e.ld = {{8{b[7]}}, b};
            end
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Advance the model at each active edge from the inputs presented in that cycle.
    always @(posedge clk) begin
        exp_t e;
        e = model();
        if (!rst_n) begin
            m_done      = 0;
            m_ptr       = 16'h0;
            m_stall_cnt = 0;
            m_acc_cnt   = 0;
        end else begin
            if (e.stall) m_stall_cnt++;
            if (is_active() && dmem_resp) m_acc_cnt++;
            if (is_active() && (mem_op == 3'd5 || mem_op == 3'd6)) begin
                if (dmem_resp) begin
                    if (m_done == 0) begin
                        m_done = 1;
                        m_ptr  = dmem_rdata;
                    end else begin
                        m_done = 0;
                    end
                end
            end else begin
                m_done = 0;
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (cmp_en) begin
            e = model();
            chk("m_read",  {31'h0, dmem_read},         {31'h0, e.rd});
            chk("m_write", {31'h0, dmem_write},        {31'h0, e.wr});
            chk("m_addr",  {16'h0, dmem_address},      {16'h0, e.addr});
            chk("m_wdata", {16'h0, dmem_wdata},        {16'h0, e.wdata});
            chk("m_be",    {30'h0, dmem_byte_enable},  {30'h0, e.be});
            chk("m_stall", {31'h0, mem_stall},         {31'h0, e.stall});
            chk("m_load",  {16'h0, load_data},         {16'h0, e.ld});
`ifdef MEM_ACCESS_PERF_EN
            chk("m_pstall", perf_stall_cycles, rst_n ? m_stall_cnt : 32'h0);
            chk("m_pacc",   perf_accesses,     rst_n ? m_acc_cnt   : 32'h0);
`else
            chk("m_pstall", perf_stall_cycles, 32'h0);
            chk("m_pacc",   perf_accesses,     32'h0);
`endif
        end
    end

    task automatic drive(input logic rn, input logic v, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] sd, input logic [15:0] rdv, input logic rsp);
        rst_n      = rn;
        valid      = v;
        mem_op     = op;
        address    = a;
        store_data = sd;
        dmem_rdata = rdv;
        dmem_resp  = rsp;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        cmp_en = 1'b1;

        // Reset holds all outputs low even with a live op and a response present.
        drive(1'b0, 1'b1, 3'd1, 16'h3001, 16'h0, 16'hBEEF, 1'b1);
        chk("rst_read",  {31'h0, dmem_read}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_load",  {16'h0, load_data}, 32'h0);
        tick();

        // LDW hit in the request cycle.
        drive(1'b1, 1'b1, 3'd1, 16'h3001, 16'h0, 16'hBEEF, 1'b1);
        chk("ldw_addr",  {16'h0, dmem_address}, 32'h3000);
        chk("ldw_be",    {30'h0, dmem_byte_enable}, 32'h3);
        chk("ldw_load",  {16'h0, load_data}, 32'hBEEF);
        chk("ldw_stall", {31'h0, mem_stall}, 32'h0);
        tick();

        // LDB odd byte, response after 3 cycles.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'd2, 16'h4003, 16'h0, 16'h1234, 1'b0);
            chk("ldb_wait_stall", {31'h0, mem_stall}, 32'h1);
            chk("ldb_be", {30'h0, dmem_byte_enable}, 32'h2);
            tick();
        end
        drive(1'b1, 1'b1, 3'd2, 16'h4003, 16'h0, 16'h80FF, 1'b1);
        chk("ldb_load",  {16'h0, load_data}, 32'hFF80);
        chk("ldb_stall", {31'h0, mem_stall}, 32'h0);
        tick();

        // STB replicates the byte and enables the low lane.
        drive(1'b1, 1'b1, 3'd4, 16'h2000, 16'h12A5, 16'h0, 1'b0);
        chk("stb_write", {31'h0, dmem_write}, 32'h1);
        chk("stb_wdata", {16'h0, dmem_wdata}, 32'hA5A5);
        chk("stb_be",    {30'h0, dmem_byte_enable}, 32'h1);
        chk("stb_stall", {31'h0, mem_stall}, 32'h1);
        tick();
        drive(1'b1, 1'b1, 3'd4, 16'h2000, 16'h12A5, 16'h0, 1'b1);
        chk("stb_done_stall", {31'h0, mem_stall}, 32'h0);
        tick();

        // STW aligned word write.
        drive(1'b1, 1'b1, 3'd3, 16'h2223, 16'hCAFE, 16'h0, 1'b1);
        chk("stw_addr",  {16'h0, dmem_address}, 32'h2222);
        chk("stw_wdata", {16'h0, dmem_wdata}, 32'hCAFE);
        tick();

        // LDI: pointer 0x5005 then data 0x7777 from 0x5004.
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h5005, 1'b1);
        chk("ldi_p_addr",  {16'h0, dmem_address}, 32'h1000);
        chk("ldi_p_stall", {31'h0, mem_stall}, 32'h1);
        chk("ldi_p_load",  {16'h0, load_data}, 32'h0);
        tick();
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h1111, 1'b0);
        chk("ldi_s_addr",  {16'h0, dmem_address}, 32'h5004);
        chk("ldi_s_read",  {31'h0, dmem_read}, 32'h1);
        chk("ldi_s_stall", {31'h0, mem_stall}, 32'h1);
        tick();
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h7777, 1'b1);
        chk("ldi_load",  {16'h0, load_data}, 32'h7777);
        chk("ldi_stall", {31'h0, mem_stall}, 32'h0);
        tick();

        // NONE, reserved op and invalid slot: no request even with a stray response.
        drive(1'b1, 1'b1, 3'd0, 16'h1234, 16'h0, 16'hFFFF, 1'b1);
        chk("none_read", {31'h0, dmem_read}, 32'h0);
        tick();
        drive(1'b1, 1'b1, 3'd7, 16'h1234, 16'h0, 16'hFFFF, 1'b1);
        chk("rsvd_stall", {31'h0, mem_stall}, 32'h0);
        tick();
        drive(1'b1, 1'b0, 3'd1, 16'h1234, 16'h0, 16'hFFFF, 1'b1);
        chk("inv_read", {31'h0, dmem_read}, 32'h0);
        tick();

        // STI interrupted by reset during the second access, then re-presented.
        drive(1'b1, 1'b1, 3'd6, 16'h1002, 16'h4321, 16'h6001, 1'b1);
        chk("sti_p_read", {31'h0, dmem_read}, 32'h1);
        tick();
        drive(1'b1, 1'b1, 3'd6, 16'h1002, 16'h4321, 16'h0, 1'b0);
        chk("sti_s_write", {31'h0, dmem_write}, 32'h1);
        chk("sti_s_addr",  {16'h0, dmem_address}, 32'h6000);
        chk("sti_s_wdata", {16'h0, dmem_wdata}, 32'h4321);
        tick();
        drive(1'b0, 1'b1, 3'd6, 16'h1002, 16'h4321, 16'h0, 1'b0);
        chk("sti_rst_write", {31'h0, dmem_write}, 32'h0);
        chk("sti_rst_addr",  {16'h0, dmem_address}, 32'h0);
        tick();
        drive(1'b1, 1'b1, 3'd6, 16'h1002, 16'h4321, 16'h6001, 1'b0);
        chk("sti_re_read", {31'h0, dmem_read}, 32'h1);
        chk("sti_re_addr", {16'h0, dmem_address}, 32'h1002);
        tick();
        drive(1'b1, 1'b1, 3'd6, 16'h1002, 16'h4321, 16'h6001, 1'b1);
        tick();
        drive(1'b1, 1'b1, 3'd6, 16'h1002, 16'h4321, 16'h0, 1'b1);
        chk("sti_done_stall", {31'h0, mem_stall}, 32'h0);
        tick();

        // LDI abandoned after its pointer fetch: slot empties, op restarts from the pointer read.
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h5005, 1'b1);
        tick();
        drive(1'b1, 1'b0, 3'd5, 16'h1000, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h5005, 1'b1);
        chk("ldi_re_addr", {16'h0, dmem_address}, 32'h1000);
        tick();
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h7777, 1'b1);
        tick();

        // Perf: clear by reset, then LDI with two-cycle latency per access.
        drive(1'b0, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h5005, 1'b1);
        tick();
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 3'd5, 16'h1000, 16'h0, 16'h7777, 1'b1);
        chk("perf_ldi_load", {16'h0, load_data}, 32'h7777);
        tick();
        drive(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
`ifdef MEM_ACCESS_PERF_EN
        chk("perf_acc",   perf_accesses,     32'd2);
        chk("perf_stall", perf_stall_cycles, 32'd3);
`else
        chk("perf_acc",   perf_accesses,     32'd0);
        chk("perf_stall", perf_stall_cycles, 32'd0);
`endif
        tick();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
